rv32_processor: RTL and testbench

Single-cycle RV32I-subset integer core: fetches from an internal instruction ROM, decodes, executes in an ALU and writes back to a 32×32 register file, one instruction per clock. Top-level compute block of the design. Exports its decoded register indices and ALU control so a bench can follow execution without a data bus.

---
 rtl/rv32_processor.sv | 198 +++++++++++++++++++
 tb/tb_rv32_processor.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_processor.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rv32_processor                                                |
// | Brief    : single-cycle RV32I-subset core with internal instruction ROM  |
// |            and 32x32 register file; REGFILE_RESET_EN adds regfile reset  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module rv32_processor #(
  parameter int    IMEM_DEPTH = 64,
  parameter string IMEM_FILE  = "program.hex"
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [4:0] rs1,
  output logic [4:0] rs2,
  output logic [4:0] rd,
  output logic [3:0] alu_ctrl
);

  localparam int c_aw = $clog2(IMEM_DEPTH);

  localparam logic [3:0] c_alu_add   = 4'b0000;
  localparam logic [3:0] c_alu_sub   = 4'b0001;
  localparam logic [3:0] c_alu_and   = 4'b0010;
  localparam logic [3:0] c_alu_or    = 4'b0011;
  localparam logic [3:0] c_alu_xor   = 4'b0100;
  localparam logic [3:0] c_alu_sll   = 4'b0101;
  localparam logic [3:0] c_alu_srl   = 4'b0110;
  localparam logic [3:0] c_alu_sra   = 4'b0111;
  localparam logic [3:0] c_alu_slt   = 4'b1000;
  localparam logic [3:0] c_alu_sltu  = 4'b1001;
  localparam logic [3:0] c_alu_passb = 4'b1010;

  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_i      = 7'b0010011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  logic [31:0] imem [0:IMEM_DEPTH-1];
  logic [31:0] regs [0:31];
  logic [31:0] pc;
  logic [31:0] pc_d;
  logic [31:0] inst;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_j;
  logic [31:0] w_rdata1;
  logic [31:0] w_rdata2;
  logic [31:0] w_op_b;
  logic [31:0] w_alu_y;
  logic [31:0] w_wb_data;
  logic        w_reg_we;
  logic        w_is_branch;
  logic        w_is_jal;

  // Fetch ignores pc[1:0] and wraps on the ROM size.
  assign inst     = imem[pc[c_aw+1:2]];
  assign w_opcode = inst[6:0];
  assign w_funct3 = inst[14:12];
  assign w_funct7 = inst[31:25];
  assign rs1      = inst[19:15];
  assign rs2      = inst[24:20];
  assign rd       = inst[11:7];

  assign w_imm_i = {{20{inst[31]}}, inst[31:20]};
  assign w_imm_u = {inst[31:12], 12'd0};
  assign w_imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign w_imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign w_rdata1 = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign w_rdata2 = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  // Unrecognised encodings fall through with no write and the ADD code.
  always_comb begin
    alu_ctrl    = c_alu_add;
    w_op_b      = w_rdata2;
    w_reg_we    = 1'b0;
    w_is_branch = 1'b0;
    w_is_jal    = 1'b0;
    case (w_opcode)
      c_op_r: begin
        w_reg_we = 1'b1;
        case ({w_funct7, w_funct3})
          {7'h00, 3'd0}: alu_ctrl = c_alu_add;
          {7'h20, 3'd0}: alu_ctrl = c_alu_sub;
          {7'h00, 3'd1}: alu_ctrl = c_alu_sll;
          {7'h00, 3'd2}: alu_ctrl = c_alu_slt;
          {7'h00, 3'd3}: alu_ctrl = c_alu_sltu;
          {7'h00, 3'd4}: alu_ctrl = c_alu_xor;
          {7'h00, 3'd5}: alu_ctrl = c_alu_srl;
          {7'h20, 3'd5}: alu_ctrl = c_alu_sra;
          {7'h00, 3'd6}: alu_ctrl = c_alu_or;
          {7'h00, 3'd7}: alu_ctrl = c_alu_and;
          default:       w_reg_we = 1'b0;
        endcase
      end
      c_op_i: begin
        w_op_b   = w_imm_i;
        w_reg_we = 1'b1;
        case (w_funct3)
          3'd0: alu_ctrl = c_alu_add;
          3'd2: alu_ctrl = c_alu_slt;
          3'd3: alu_ctrl = c_alu_sltu;
          3'd4: alu_ctrl = c_alu_xor;
          3'd6: alu_ctrl = c_alu_or;
          3'd7: alu_ctrl = c_alu_and;
          3'd1: begin
            if (w_funct7 == 7'h00) alu_ctrl = c_alu_sll;
            else                   w_reg_we = 1'b0;
          end
          default: begin
            if (w_funct7 == 7'h00)      alu_ctrl = c_alu_srl;
            else if (w_funct7 == 7'h20) alu_ctrl = c_alu_sra;
            else                        w_reg_we = 1'b0;
          end
        endcase
      end
      c_op_lui: begin
        w_op_b   = w_imm_u;
        alu_ctrl = c_alu_passb;
        w_reg_we = 1'b1;
      end
      c_op_branch: begin
        if (w_funct3[2:1] == 2'b00) begin
          alu_ctrl    = c_alu_sub;
          w_is_branch = 1'b1;
        end
      end
      c_op_jal: begin
        w_reg_we = 1'b1;
        w_is_jal = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_alu_y = 32'd0;
    case (alu_ctrl)
      c_alu_add:   w_alu_y = w_rdata1 + w_op_b;
      c_alu_sub:   w_alu_y = w_rdata1 - w_op_b;
      c_alu_and:   w_alu_y = w_rdata1 & w_op_b;
      c_alu_or:    w_alu_y = w_rdata1 | w_op_b;
      c_alu_xor:   w_alu_y = w_rdata1 ^ w_op_b;
      c_alu_sll:   w_alu_y = w_rdata1 << w_op_b[4:0];
      c_alu_srl:   w_alu_y = w_rdata1 >> w_op_b[4:0];
      c_alu_sra:   w_alu_y = $unsigned($signed(w_rdata1) >>> w_op_b[4:0]);
      c_alu_slt:   w_alu_y = {31'd0, $signed(w_rdata1) < $signed(w_op_b)};
      c_alu_sltu:  w_alu_y = {31'd0, w_rdata1 < w_op_b};
      c_alu_passb: w_alu_y = w_op_b;
      default:     w_alu_y = 32'd0;
    endcase
  end

  // funct3[0] distinguishes BNE from BEQ: it inverts the zero test.
  always_comb begin
    pc_d = pc + 32'd4;
    if (w_is_jal)
      pc_d = pc + w_imm_j;
    else if (w_is_branch && ((w_alu_y == 32'd0) != w_funct3[0]))
      pc_d = pc + w_imm_b;
  end

  assign w_wb_data = w_is_jal ? (pc + 32'd4) : w_alu_y;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) pc <= 32'd0;
    else      pc <= pc_d;
  end

`ifdef REGFILE_RESET_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      if (w_reg_we) regs[rd] <= w_wb_data;
      regs[0] <= 32'd0;
    end
  end
`else
  // Contents survive reset; a clock edge seen while RST is low writes nothing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      if (w_reg_we) regs[rd] <= w_wb_data;
      regs[0] <= 32'd0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32_processor.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for rv32_processor: directed scenarios plus random programs run
// against a mnemonic-level instruction-set model.
module tb_rv32_processor;
  localparam int IMEM_DEPTH = 64;

  localparam int M_ADD = 0, M_SUB = 1, M_AND = 2, M_OR = 3, M_XOR = 4, M_SLL = 5;
  localparam int M_SRL = 6, M_SRA = 7, M_SLT = 8, M_SLTU = 9, M_ADDI = 10;
  localparam int M_ANDI = 11, M_ORI = 12, M_XORI = 13, M_SLTI = 14, M_SLTIU = 15;
  localparam int M_SLLI = 16, M_SRLI = 17, M_SRAI = 18, M_LUI = 19, M_BEQ = 20;
  localparam int M_BNE = 21, M_JAL = 22, M_BAD_LOAD = 23, M_BAD_MUL = 24;
  localparam int M_BAD_SHI = 25, M_BAD_BR = 26, M_COUNT = 27;

  logic       CLK;
  logic       RST;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic [3:0] alu_ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] pw   [0:IMEM_DEPTH-1];
  int          pop  [0:IMEM_DEPTH-1];
  logic [4:0]  prd  [0:IMEM_DEPTH-1];
  logic [4:0]  prs1 [0:IMEM_DEPTH-1];
  logic [4:0]  prs2 [0:IMEM_DEPTH-1];
  logic [31:0] pimm [0:IMEM_DEPTH-1];
  logic [31:0] mregs [0:31];
  logic [31:0] mpc;

  rv32_processor #(.IMEM_DEPTH(IMEM_DEPTH), .IMEM_FILE("")) dut (
    .CLK(CLK), .RST(RST), .rs1(rs1), .rs2(rs2), .rd(rd), .alu_ctrl(alu_ctrl)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] exp_ctrl(input int op);
    case (op)
      M_SUB, M_BEQ, M_BNE: return 4'd1;
      M_AND, M_ANDI:       return 4'd2;
      M_OR, M_ORI:         return 4'd3;
      M_XOR, M_XORI:       return 4'd4;
      M_SLL, M_SLLI:       return 4'd5;
      M_SRL, M_SRLI:       return 4'd6;
      M_SRA, M_SRAI:       return 4'd7;
      M_SLT, M_SLTI:       return 4'd8;
      M_SLTU, M_SLTIU:     return 4'd9;
      M_LUI:               return 4'd10;
      default:             return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] assemble(input int op, input logic [4:0] d,
                                           input logic [4:0] s1, input logic [4:0] s2,
                                           input logic [31:0] im);
    logic [31:0] w;
    w = 32'h0000_0013;
    case (op)
      M_ADD:      w = {7'h00, s2, s1, 3'd0, d, 7'h33};
      M_SUB:      w = {7'h20, s2, s1, 3'd0, d, 7'h33};
      M_SLL:      w = {7'h00, s2, s1, 3'd1, d, 7'h33};
      M_SLT:      w = {7'h00, s2, s1, 3'd2, d, 7'h33};
      M_SLTU:     w = {7'h00, s2, s1, 3'd3, d, 7'h33};
      M_XOR:      w = {7'h00, s2, s1, 3'd4, d, 7'h33};
      M_SRL:      w = {7'h00, s2, s1, 3'd5, d, 7'h33};
      M_SRA:      w = {7'h20, s2, s1, 3'd5, d, 7'h33};
      M_OR:       w = {7'h00, s2, s1, 3'd6, d, 7'h33};
      M_AND:      w = {7'h00, s2, s1, 3'd7, d, 7'h33};
      M_ADDI:     w = {im[11:0], s1, 3'd0, d, 7'h13};
      M_SLTI:     w = {im[11:0], s1, 3'd2, d, 7'h13};
      M_SLTIU:    w = {im[11:0], s1, 3'd3, d, 7'h13};
      M_XORI:     w = {im[11:0], s1, 3'd4, d, 7'h13};
      M_ORI:      w = {im[11:0], s1, 3'd6, d, 7'h13};
      M_ANDI:     w = {im[11:0], s1, 3'd7, d, 7'h13};
      M_SLLI:     w = {7'h00, im[4:0], s1, 3'd1, d, 7'h13};
      M_SRLI:     w = {7'h00, im[4:0], s1, 3'd5, d, 7'h13};
      M_SRAI:     w = {7'h20, im[4:0], s1, 3'd5, d, 7'h13};
      M_LUI:      w = {im[19:0], d, 7'h37};
      M_BEQ:      w = {im[12], im[10:5], s2, s1, 3'd0, im[4:1], im[11], 7'h63};
      M_BNE:      w = {im[12], im[10:5], s2, s1, 3'd1, im[4:1], im[11], 7'h63};
      M_BAD_BR:   w = {im[12], im[10:5], s2, s1, 3'd4, im[4:1], im[11], 7'h63};
      M_JAL:      w = {im[20], im[10:1], im[11], im[19:12], d, 7'h6F};
      M_BAD_LOAD: w = {im[11:0], s1, 3'd2, d, 7'h03};
      M_BAD_MUL:  w = {7'h01, s2, s1, 3'd0, d, 7'h33};
      M_BAD_SHI:  w = {7'h20, im[4:0], s1, 3'd1, d, 7'h13};
      default:    w = 32'h0000_0013;
    endcase
    return w;
  endfunction

  // One instruction of the architectural model, interpreted from its mnemonic.
  task automatic model_step(input int i);
    logic [31:0] a, b, im, r, nxt;
    bit wr;
    a = mregs[prs1[i]]; b = mregs[prs2[i]]; im = pimm[i];
    nxt = mpc + 32'd4; wr = 1'b1; r = 32'd0;
    case (pop[i])
      M_ADD:   r = a + b;
      M_SUB:   r = a - b;
      M_AND:   r = a & b;
      M_OR:    r = a | b;
      M_XOR:   r = a ^ b;
      M_SLL:   r = a << b[4:0];
      M_SRL:   r = a >> b[4:0];
      M_SRA:   r = $unsigned($signed(a) >>> b[4:0]);
      M_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      M_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
      M_ADDI:  r = a + im;
      M_ANDI:  r = a & im;
      M_ORI:   r = a | im;
      M_XORI:  r = a ^ im;
      M_SLTI:  r = ($signed(a) < $signed(im)) ? 32'd1 : 32'd0;
      M_SLTIU: r = (a < im) ? 32'd1 : 32'd0;
      M_SLLI:  r = a << im[4:0];
      M_SRLI:  r = a >> im[4:0];
      M_SRAI:  r = $unsigned($signed(a) >>> im[4:0]);
      M_LUI:   r = im << 12;
      M_BEQ:   begin wr = 1'b0; if (a == b) nxt = mpc + im; end
      M_BNE:   begin wr = 1'b0; if (a != b) nxt = mpc + im; end
      M_JAL:   begin r = mpc + 32'd4; nxt = mpc + im; end
      default: wr = 1'b0;
    endcase
    if (wr && prd[i] != 5'd0) mregs[prd[i]] = r;
    mpc = nxt;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < IMEM_DEPTH; i++) pw[i] = 32'h0000_0013;
  endtask

  task automatic load_and_reset();
    @(posedge CLK); #2;
    RST = 1'b0;
    for (int i = 0; i < IMEM_DEPTH; i++) dut.imem[i] = pw[i];
    #2;
    RST = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] got [6];
    logic [31:0] exp [6];
    string nm [6];
    fill_nop();
    pw[0] = 32'h00500093; pw[1] = 32'h00300113; pw[2] = 32'h402081B3; pw[3] = 32'h00700013;
    for (int i = 0; i < IMEM_DEPTH; i++) dut.imem[i] = pw[i];
    RST = 1'b1;
    #10 RST = 1'b0;
    #2;
    got[0] = dut.pc;       exp[0] = 32'h0;        nm[0] = "reset_pc";
    got[1] = dut.inst;     exp[1] = 32'h00500093; nm[1] = "reset_inst";
    got[2] = 32'(rs1);     exp[2] = 32'd0;        nm[2] = "reset_rs1";
    got[3] = 32'(rs2);     exp[3] = 32'd5;        nm[3] = "reset_rs2";
    got[4] = 32'(rd);      exp[4] = 32'd1;        nm[4] = "reset_rd";
    got[5] = 32'(alu_ctrl); exp[5] = 32'd0;       nm[5] = "reset_alu_ctrl";
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (got[k] !== exp[k]) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm[k], got[k], exp[k]);
      end
    end
    #8 RST = 1'b1;
  endtask

  task automatic test_program();
    logic [31:0] got [8];
    logic [31:0] exp [8];
    @(posedge CLK); #1;
    n_checks++;
    if (dut.pc !== 32'h4) begin n_fail++; $display("FAIL prog_pc1: got %h expected %h", dut.pc, 32'h4); end
    @(posedge CLK); #1;
    got[0] = dut.pc;        exp[0] = 32'h8;
    got[1] = dut.inst;      exp[1] = 32'h402081B3;
    got[2] = 32'(rs1);      exp[2] = 32'd1;
    got[3] = 32'(rs2);      exp[3] = 32'd2;
    got[4] = 32'(rd);       exp[4] = 32'd3;
    got[5] = 32'(alu_ctrl); exp[5] = 32'd1;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (got[k] !== exp[k]) begin
        n_fail++; $display("FAIL prog_sub_decode[%0d]: got %h expected %h", k, got[k], exp[k]);
      end
    end
    @(posedge CLK); #1;
    got[0] = dut.regs[1]; exp[0] = 32'd5;
    got[1] = dut.regs[2]; exp[1] = 32'd3;
    got[2] = dut.regs[3]; exp[2] = 32'd2;
    got[3] = dut.pc;      exp[3] = 32'hC;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got[k] !== exp[k]) begin
        n_fail++; $display("FAIL prog_result[%0d]: got %h expected %h", k, got[k], exp[k]);
      end
    end
    @(posedge CLK); #1;
    n_checks++;
    if (dut.regs[0] !== 32'd0) begin n_fail++; $display("FAIL x0_write: got %h expected %h", dut.regs[0], 32'd0); end
  endtask

  task automatic test_branch(input logic [31:0] br, input logic [31:0] exp_pc, input string nm);
    fill_nop();
    pw[0] = 32'h00500093; pw[3] = br;
    load_and_reset();
    repeat (3) begin @(posedge CLK); #1; end
    n_checks++;
    if (alu_ctrl !== 4'd1 || dut.pc !== 32'hC) begin
      n_fail++; $display("FAIL %s_decode: got alu %h pc %h expected alu 1 pc c", nm, alu_ctrl, dut.pc);
    end
    @(posedge CLK); #1;
    n_checks++;
    if (dut.pc !== exp_pc) begin n_fail++; $display("FAIL %s_next_pc: got %h expected %h", nm, dut.pc, exp_pc); end
  endtask

  task automatic test_lui();
    fill_nop();
    pw[0] = 32'h123452B7;
    load_and_reset();
    n_checks++;
    if (alu_ctrl !== 4'd10 || rd !== 5'd5) begin
      n_fail++; $display("FAIL lui_decode: got alu %h rd %0d expected alu a rd 5", alu_ctrl, rd);
    end
    @(posedge CLK); #1;
    n_checks++;
    if (dut.regs[5] !== 32'h12345000) begin
      n_fail++; $display("FAIL lui_result: got %h expected %h", dut.regs[5], 32'h12345000);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] e [1:3];
    fill_nop();
    pw[0] = 32'h00500093; pw[1] = 32'h00300113; pw[2] = 32'h402081B3; pw[3] = 32'h00900193;
    load_and_reset();
    repeat (4) begin @(posedge CLK); #1; end
    n_checks++;
    if (dut.regs[3] !== 32'd9) begin n_fail++; $display("FAIL mid_pre_x3: got %h expected %h", dut.regs[3], 32'd9); end
    load_and_reset();
    repeat (2) begin @(posedge CLK); #1; end
    n_checks++;
    if (dut.pc !== 32'h8) begin n_fail++; $display("FAIL mid_pc8: got %h expected %h", dut.pc, 32'h8); end
    #2 RST = 1'b0;
    #1;
    n_checks++;
    if (dut.pc !== 32'h0 || dut.inst !== 32'h00500093) begin
      n_fail++; $display("FAIL mid_async_pc: got pc %h inst %h expected pc 0 inst 00500093", dut.pc, dut.inst);
    end
    #9 RST = 1'b1;
    #1;
    n_checks++;
    if (dut.pc !== 32'h0) begin n_fail++; $display("FAIL mid_hold_pc: got %h expected %h", dut.pc, 32'h0); end
`ifdef REGFILE_RESET_EN
    e[1] = 32'd0; e[2] = 32'd0; e[3] = 32'd0;
`else
    e[1] = 32'd5; e[2] = 32'd3; e[3] = 32'd9;
`endif
    for (int k = 1; k <= 3; k++) begin
      n_checks++;
      if (dut.regs[k] !== e[k]) begin
        n_fail++; $display("FAIL mid_regs x%0d: got %h expected %h", k, dut.regs[k], e[k]);
      end
    end
    @(posedge CLK); #1;
    n_checks++;
    if (dut.pc !== 32'h4) begin n_fail++; $display("FAIL mid_restart_pc: got %h expected %h", dut.pc, 32'h4); end
  endtask

  task automatic gen_program();
    int op;
    logic [31:0] v;
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      prs1[i] = 5'($urandom_range(0, 7));
      prs2[i] = 5'($urandom_range(0, 7));
      prd[i]  = 5'($urandom_range(0, 7));
      if (i < 7) begin
        op = M_LUI; prd[i] = 5'(i + 1);
      end else begin
        op = int'($urandom_range(0, M_COUNT - 1));
      end
      v = $urandom;
      case (op)
        M_ADDI, M_ANDI, M_ORI, M_XORI, M_SLTI, M_SLTIU, M_BAD_LOAD: v = {{20{v[11]}}, v[11:0]};
        M_SLLI, M_SRLI, M_SRAI, M_BAD_SHI: v = v & 32'h1F;
        M_LUI: v = v & 32'hFFFFF;
        M_BEQ, M_BNE, M_BAD_BR, M_JAL: begin
          v = 32'($urandom_range(1, (op == M_JAL) ? 8 : 4)) << 2;
          if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
        end
        default: v = 32'd0;
      endcase
      pop[i] = op; pimm[i] = v;
      pw[i] = assemble(op, prd[i], prs1[i], prs2[i], v);
    end
  endtask

  task automatic test_random_programs();
    int idx;
    logic [31:0] w;
    for (int p = 0; p < 4; p++) begin
      gen_program();
      load_and_reset();
      for (int k = 0; k < 32; k++) mregs[k] = 32'd0;
      mpc = 32'd0;
      for (int c = 0; c < 150; c++) begin
        idx = int'(mpc[7:2]);
        w = pw[idx];
        n_checks++;
        if (dut.pc !== mpc) begin n_fail++; $display("FAIL rnd_pc p%0d c%0d: got %h expected %h", p, c, dut.pc, mpc); end
        n_checks++;
        if (rs1 !== w[19:15] || rs2 !== w[24:20] || rd !== w[11:7]) begin
          n_fail++; $display("FAIL rnd_fields p%0d c%0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                             p, c, rs1, rs2, rd, w[19:15], w[24:20], w[11:7]);
        end
        n_checks++;
        if (alu_ctrl !== exp_ctrl(pop[idx])) begin
          n_fail++; $display("FAIL rnd_alu_ctrl p%0d c%0d inst %h: got %h expected %h",
                             p, c, w, alu_ctrl, exp_ctrl(pop[idx]));
        end
        model_step(idx);
        @(posedge CLK); #1;
      end
      for (int k = 0; k < 8; k++) begin
        n_checks++;
        if (dut.regs[k] !== mregs[k]) begin
          n_fail++; $display("FAIL rnd_reg p%0d x%0d: got %h expected %h", p, k, dut.regs[k], mregs[k]);
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    test_reset();
    test_program();
    test_branch(32'h00108463, 32'h14, "beq");
    test_branch(32'h00109463, 32'h10, "bne");
    test_lui();
    test_mid_reset();
    test_random_programs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
